register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/mips_pkg.sv | 17 +
 rtl/regfile_read_port.sv | 55 +++++
 rtl/register_file.sv | 78 +++++++
 tb/tb_register_file.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: data width, register address width, special register numbers.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
  localparam reg_addr_t REG_RA   = reg_addr_t'(31);

  // A same-edge write targets this read address and is a real (non-r0) write.
  function automatic logic addr_hit(input logic en, input reg_addr_t wr_addr, input reg_addr_t rd_addr);
    return en && (wr_addr != REG_ZERO) && (wr_addr == rd_addr);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered register-file read port: address mux, optional write bypass
// (REGFILE_BYPASS_EN), and output hold while the read enable is low.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rd_en_i,
  input  logic [ADDR_W-1:0]                rd_addr_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
  input  logic                             wr_en_i,
  input  logic [ADDR_W-1:0]                wr_addr_i,
  input  logic [DATA_W-1:0]                wr_data_i,
  output logic [DATA_W-1:0]                rd_data_o
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;

`ifndef REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  // Addresses beyond NUM_REGS read as zero; entry 0 is held at zero by the array.
  always_comb begin
    rd_data_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        rd_data_d = regs_i[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (addr_hit(wr_en_i, reg_addr_t'(wr_addr_i), reg_addr_t'(rd_addr_i))) begin
      rd_data_d = wr_data_i;
    end
`endif
    if (!rd_en_i) begin
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/register_file.sv
// MIPS register file: r0 hard-wired to zero, two registered read ports with stall hold.
// Define REGFILE_BYPASS_EN for write-before-read forwarding on same-edge conflicts.
module register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Write_Register,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Read_Register1,
  input  logic [ADDR_W-1:0] Read_Register2,
  input  logic              ReadEn,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  output logic              Read_Valid
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d, regs_q;
  logic                            valid_q;

  // Writes land on the edge regardless of ReadEn; r0 and out-of-range addresses drop.
  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (RegWrite && (Write_Register == ADDR_W'(i))) begin
        regs_d[i] = Write_Data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      valid_q <= ReadEn;
    end
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_port1 (
    .clk       (clk),
    .reset     (reset),
    .rd_en_i   (ReadEn),
    .rd_addr_i (Read_Register1),
    .regs_i    (regs_q),
    .wr_en_i   (RegWrite),
    .wr_addr_i (Write_Register),
    .wr_data_i (Write_Data),
    .rd_data_o (Read_Data1)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_port2 (
    .clk       (clk),
    .reset     (reset),
    .rd_en_i   (ReadEn),
    .rd_addr_i (Read_Register2),
    .regs_i    (regs_q),
    .wr_en_i   (RegWrite),
    .wr_addr_i (Write_Register),
    .wr_data_i (Write_Data),
    .rd_data_o (Read_Data2)
  );

  assign Read_Valid = valid_q;

endmodule

// File: tb/tb_register_file.sv
// Directed table-driven bench for register_file, plus hand-written reset sequences.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  Write_Register;
  logic [31:0] Write_Data;
  logic [4:0]  Read_Register1;
  logic [4:0]  Read_Register2;
  logic        ReadEn;
  logic [31:0] Read_Data1;
  logic [31:0] Read_Data2;
  logic        Read_Valid;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] CONFLICT_R7 = 32'h0000_00AA;
`else
  localparam logic [31:0] CONFLICT_R7 = 32'h0000_0011;
`endif

  register_file dut (
    .clk            (clk),
    .reset          (reset),
    .RegWrite       (RegWrite),
    .Write_Register (Write_Register),
    .Write_Data     (Write_Data),
    .Read_Register1 (Read_Register1),
    .Read_Register2 (Read_Register2),
    .ReadEn         (ReadEn),
    .Read_Data1     (Read_Data1),
    .Read_Data2     (Read_Data2),
    .Read_Valid     (Read_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        expv;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [31:0] e1, input logic [31:0] e2, input logic ev);
    check({name, ".rd1"}, Read_Data1, e1);
    check({name, ".rd2"}, Read_Data2, e2);
    check({name, ".valid"}, 32'(Read_Valid), 32'(ev));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra1, input logic [4:0] ra2);
    RegWrite       = we;
    Write_Register = wa;
    Write_Data     = wd;
    ReadEn         = re;
    Read_Register1 = ra1;
    Read_Register2 = ra2;
  endtask

  initial begin
    // Expected outputs are those visible just after the edge that consumes the row.
    vecs[0]  = '{1'b1, 5'd1,  32'h1,         1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b1, 5'd2,  32'h2,         1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         1'b0};
    vecs[2]  = '{1'b1, 5'd3,  32'h3,         1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd1,  5'd3,  32'h1,         32'h3,         1'b1};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd2,  5'd1,  32'h2,         32'h1,         1'b1};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd2,  32'h0,         32'h2,         1'b1};
    vecs[6]  = '{1'b1, 5'd31, 32'h0040_0008, 1'b0, 5'd0,  5'd0,  32'h0,         32'h2,         1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 5'd31, 32'h0040_0008, 32'h0040_0008, 1'b1};
    vecs[8]  = '{1'b1, 5'd7,  32'h11,        1'b1, 5'd1,  5'd2,  32'h1,         32'h2,         1'b1};
    vecs[9]  = '{1'b1, 5'd7,  32'hAA,        1'b1, 5'd7,  5'd7,  CONFLICT_R7,   CONFLICT_R7,   1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  5'd0,  32'hAA,        32'h0,         1'b1};
    vecs[11] = '{1'b1, 5'd0,  32'h5,         1'b1, 5'd0,  5'd1,  32'h0,         32'h1,         1'b1};
    vecs[12] = '{1'b1, 5'd3,  32'h55,        1'b0, 5'd3,  5'd3,  32'h0,         32'h1,         1'b0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd3,  5'd3,  32'h0,         32'h1,         1'b0};
    vecs[14] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd3,  5'd3,  32'h0,         32'h1,         1'b0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  5'd3,  32'h55,        32'h55,        1'b1};
    vecs[16] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd1,  5'd2,  32'h55,        32'h55,        1'b0};

    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    step();
    step();
    check_outs("reset_state", 32'h0, 32'h0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra1, vecs[i].ra2);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp2, vecs[i].expv);
    end

    // Write r5, read it back, then assert reset between edges.
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
    step();
    check_outs("r5_before_reset", 32'h1234, 32'h1234, 1'b1);
    reset = 1'b1;
    #1;
    check_outs("async_reset", 32'h0, 32'h0, 1'b0);

    // A write presented on an edge while reset is high must be dropped.
    drive(1'b1, 5'd6, 32'hBEEF, 1'b1, 5'd6, 5'd5);
    step();
    check_outs("reset_held", 32'h0, 32'h0, 1'b0);
    reset = 1'b0;

    // First edge after reset accepts a write; no read yet.
    drive(1'b1, 5'd9, 32'h9, 1'b0, 5'd5, 5'd6);
    step();
    check_outs("post_reset_idle", 32'h0, 32'h0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6);
    step();
    check_outs("post_reset_r5_r6", 32'h0, 32'h0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd31);
    step();
    check_outs("post_reset_r9_r31", 32'h9, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
